btn_evt: RTL and testbench
==========================

// Module: btn_evt
// PURPOSE
//  Button gesture classifier; sits directly downstream of the debouncer, consuming its
//  clean level output. Converts that level into one-cycle event pulses: press, release,
//  single click, double click, long press. Feeds control FSMs, which must never see bounce.
// PARAMETERS
//  CNT_W     16   width of the shared interval counter
//  LONG_CYC  1000 cycles of continuous hold that classify a press as long (2..2**CNT_W-1)
//  DBL_CYC   250  max release gap, in cycles, before a second press (2..2**CNT_W-1)
// PORTS
//  clk        in   1  system clock; all logic on posedge
//  rst_n      in   1  synchronous active-low reset
//  in         in   1  debounced button level, active-high, synchronous to clk
//  held       out  1  registered copy of in (current pressed level)
//  press      out  1  1-cycle pulse on each 0->1 of in
//  release    out  1  1-cycle pulse on each 1->0 of in
//  click      out  1  1-cycle pulse: short press, then no 2nd press within DBL_CYC
//  dbl_click  out  1  1-cycle pulse: two short presses, gap < DBL_CYC
//  long_press out  1  1-cycle pulse when a hold reaches LONG_CYC
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, cnt=0, in_q=0, all outputs 0.
//    If in is high when reset releases, press fires 1 cycle later; the gesture starts then.
//  - Edge detect: rise = in & ~in_q; fall = ~in & in_q.
//    in_q is updated every clock. held = in_q.
//  - All outputs are registered. Latency is 1 clk from the edge that samples the in change
//    to the asserted pulse. Each pulse is high for exactly 1 cycle.
//  - press/release follow rise/fall unconditionally, in every state.
//  - FSM (cnt is cleared on every state change; otherwise cnt+1 each cycle):
//    IDLE   : rise -> PRESS1.
//    PRESS1 : fall -> WAIT2.
//             else cnt==LONG_CYC-1 -> long_press, LONG.
//    LONG   : fall -> IDLE. No click is emitted.
//    WAIT2  : rise -> PRESS2.
//             else cnt==DBL_CYC-1 -> click, IDLE.
//    PRESS2 : fall -> dbl_click, IDLE.
//             else cnt==LONG_CYC-1 -> long_press, LONG. The first click is discarded.
//  - Simultaneous events: an edge wins over counter expiry in the same cycle.
//    Example: rise at cnt==DBL_CYC-1 -> PRESS2, no click.
//  - cnt never exceeds max(LONG_CYC,DBL_CYC)-1; no wrap is possible. Counter is CNT_W bits,
//    unsigned. Compares use CNT_W-bit constants.
//  - click, dbl_click and long_press are mutually exclusive in any cycle.
//    press and release are never both high.
//  - Reset mid-gesture: the gesture is abandoned and no pulse is emitted.
//    Outputs are 0 in the cycle after the reset edge.
// STRUCTURE
//  - Shared header btn_evt_defs.vh: 3-bit state encodings (IDLE, PRESS1, LONG, WAIT2,
//    PRESS2) and default timing constants, reused by the top-level button wrapper.
//  - One sub-module: edge_det (in, in_q register, rise/fall outputs, sync active-low reset).
//  - Top: FSM state register, interval counter, registered output stage.
// TESTING  (LONG_CYC=20, DBL_CYC=8)
//  1 Reset: rst_n low for 3 clk with in=0 -> all outputs 0.
//    Hold rst_n low mid-PRESS1 -> no pulses; state IDLE.
//  2 Single click: in high 5 clk, then low 20 clk -> press, release, then click exactly once,
//    8 clk after release. No dbl_click.
//  3 Double click: high 5, low 3, high 5, low -> press x2, release x2,
//    dbl_click 1 clk after the 2nd fall. No click.
//  4 Long press: high 30 clk -> long_press 20 clk after the rise; release at the fall.
//    No click or dbl_click.
//  5 Boundary: 2nd rise lands on the cycle cnt==7 in WAIT2 -> PRESS2, no click.
//    Fall lands on cnt==19 in PRESS1 -> WAIT2, no long_press.
//  6 Second press held long: high 5, low 3, high 25 -> single long_press.
//    No click or dbl_click.

Source files
------------

// File: rtl/btn_evt_pkg.sv
// Shared types and default timing for the button gesture classifier.
// State encodings are reused by the top-level button wrapper.
package btn_evt_pkg;

  localparam int unsigned CntWDef    = 16;
  localparam int unsigned LongCycDef = 1000;
  localparam int unsigned DblCycDef  = 250;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StPress1 = 3'd1,
    StLong   = 3'd2,
    StWait2  = 3'd3,
    StPress2 = 3'd4
  } btn_state_e;

  typedef struct packed {
    logic press;
    logic rel;
    logic click;
    logic dbl_click;
    logic long_press;
  } btn_evt_t;

endpackage

// File: rtl/btn_evt_if.sv
// Button level in, gesture pulses out. The slave side is the classifier.
// The release pulse is named rel because release is a reserved word.
interface btn_evt_if;
  logic in;
  logic held;
  logic press;
  logic rel;
  logic click;
  logic dbl_click;
  logic long_press;

  modport master (
    output in,
    input  held, press, rel, click, dbl_click, long_press
  );

  modport slave (
    input  in,
    output held, press, rel, click, dbl_click, long_press
  );
endinterface

// File: rtl/btn_evt_edge_det.sv
// Registers the debounced level and flags its rising and falling edges.
module btn_evt_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  output logic in_q_o,
  output logic rise_o,
  output logic fall_o
);

  logic in_d, in_q;

  always_comb begin
    in_d = in_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in_d;
    end
  end

  assign in_q_o = in_q;
  assign rise_o = in_i & ~in_q;
  assign fall_o = ~in_i & in_q;

endmodule

// File: rtl/btn_evt.sv
// Button gesture classifier: turns a clean level into one-cycle press, release,
// click, double-click and long-press pulses, all registered.
module btn_evt
  import btn_evt_pkg::*;
#(
  parameter int unsigned CntW    = CntWDef,
  parameter int unsigned LongCyc = LongCycDef,
  parameter int unsigned DblCyc  = DblCycDef
) (
  input  logic       clk,
  input  logic       rst_n,
  btn_evt_if.slave   bus
);

  localparam logic [CntW-1:0] LongLast = CntW'(LongCyc - 1);
  localparam logic [CntW-1:0] DblLast  = CntW'(DblCyc - 1);

  logic       in_q, rise, fall;
  btn_state_e state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  btn_evt_t   evt_d, evt_q;

  btn_evt_edge_det u_edge_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_i   (bus.in),
    .in_q_o (in_q),
    .rise_o (rise),
    .fall_o (fall)
  );

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q + CntW'(1);
    evt_d           = '0;
    evt_d.press     = rise;
    evt_d.rel       = fall;

    case (state_q)
      StIdle: begin
        if (rise) state_d = StPress1;
      end
      StPress1: begin
        if (fall) begin
          state_d = StWait2;
        end else if (cnt_q == LongLast) begin
          evt_d.long_press = 1'b1;
          state_d          = StLong;
        end
      end
      StLong: begin
        if (fall) state_d = StIdle;
      end
      StWait2: begin
        // An edge outranks gap expiry in the same cycle.
        if (rise) begin
          state_d = StPress2;
        end else if (cnt_q == DblLast) begin
          evt_d.click = 1'b1;
          state_d     = StIdle;
        end
      end
      StPress2: begin
        if (fall) begin
          evt_d.dbl_click = 1'b1;
          state_d         = StIdle;
        end else if (cnt_q == LongLast) begin
          evt_d.long_press = 1'b1;
          state_d          = StLong;
        end
      end
      default: state_d = StIdle;
    endcase

    // Untimed states park the counter so it can never wrap.
    if (state_d != state_q || state_q == StIdle || state_q == StLong) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
    end
  end

  assign bus.held       = in_q;
  assign bus.press      = evt_q.press;
  assign bus.rel        = evt_q.rel;
  assign bus.click      = evt_q.click;
  assign bus.dbl_click  = evt_q.dbl_click;
  assign bus.long_press = evt_q.long_press;

endmodule

// File: tb/tb_btn_evt.sv
// Directed bench for btn_evt: expected pulses are queued with their cycle and
// matched against the outputs sampled on each falling clock edge.
module tb_btn_evt;
  import btn_evt_pkg::*;

  localparam int unsigned LongCyc = 20;
  localparam int unsigned DblCyc  = 8;

  localparam logic [4:0] EvPress = 5'b10000;
  localparam logic [4:0] EvRel   = 5'b01000;
  localparam logic [4:0] EvClick = 5'b00100;
  localparam logic [4:0] EvDbl   = 5'b00010;
  localparam logic [4:0] EvLong  = 5'b00001;

  typedef struct {
    logic [4:0] kind;
    int         at;
  } exp_t;

  exp_t q[$];
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic exp_held = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   c;

  btn_evt_if bus ();

  btn_evt #(
    .CntW    (16),
    .LongCyc (LongCyc),
    .DblCyc  (DblCyc)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic expect_evt(input logic [4:0] kind, input int at);
    exp_t e;
    if (q.size() > 0 && q[q.size()-1].at == at) begin
      e = q.pop_back();
      e.kind = e.kind | kind;
    end else begin
      e.kind = kind;
      e.at   = at;
    end
    q.push_back(e);
  endtask

  task automatic tick(input logic v);
    logic [4:0] obs, expv;
    exp_t e;
    bus.in = v;
    @(posedge clk);
    cyc++;
    exp_held = rst_n ? v : 1'b0;
    @(negedge clk);
    obs  = {bus.press, bus.rel, bus.click, bus.dbl_click, bus.long_press};
    expv = '0;
    if (q.size() > 0 && q[0].at == cyc) begin
      e = q.pop_front();
      expv = e.kind;
    end
    if (obs != '0 || expv != '0) begin
      checks++;
      assert (obs === expv) else begin
        failures++;
        $error("FAIL evt cyc=%0d observed=%b expected=%b (press,rel,click,dbl,long)",
               cyc, obs, expv);
      end
    end
    checks++;
    assert (bus.held === exp_held) else begin
      failures++;
      $error("FAIL held cyc=%0d observed=%b expected=%b", cyc, bus.held, exp_held);
    end
  endtask

  task automatic run(input logic v, input int n);
    for (int i = 0; i < n; i++) tick(v);
  endtask

  task automatic check_quiet(input string tag);
    logic [4:0] obs;
    obs = {bus.press, bus.rel, bus.click, bus.dbl_click, bus.long_press};
    checks++;
    assert (obs === 5'b00000) else begin
      failures++;
      $error("FAIL %s observed=%b expected=00000", tag, obs);
    end
  endtask

  initial begin
    bus.in = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);

    // Reset with input low
    run(1'b0, 3);
    check_quiet("reset");
    rst_n = 1'b1;

    // Reset in the middle of PRESS1: no release, no click, no long press
    c = cyc;
    expect_evt(EvPress, c + 1);
    run(1'b1, 4);
    rst_n = 1'b0;
    run(1'b0, 2);
    check_quiet("rst_mid");
    rst_n = 1'b1;
    run(1'b0, 30);

    // Input already high when reset releases: press one cycle later
    rst_n = 1'b0;
    run(1'b1, 2);
    rst_n = 1'b1;
    c = cyc;
    expect_evt(EvPress, c + 1);
    expect_evt(EvRel,   c + 4);
    expect_evt(EvClick, c + 4 + DblCyc);
    run(1'b1, 3);
    run(1'b0, 15);

    // Single click
    c = cyc;
    expect_evt(EvPress, c + 1);
    expect_evt(EvRel,   c + 6);
    expect_evt(EvClick, c + 6 + DblCyc);
    run(1'b1, 5);
    run(1'b0, 20);

    // Double click
    c = cyc;
    expect_evt(EvPress,       c + 1);
    expect_evt(EvRel,         c + 6);
    expect_evt(EvPress,       c + 9);
    expect_evt(EvRel | EvDbl, c + 14);
    run(1'b1, 5);
    run(1'b0, 3);
    run(1'b1, 5);
    run(1'b0, 15);

    // Long press
    c = cyc;
    expect_evt(EvPress, c + 1);
    expect_evt(EvLong,  c + 1 + LongCyc);
    expect_evt(EvRel,   c + 31);
    run(1'b1, 30);
    run(1'b0, 10);

    // Second rise exactly at gap expiry wins over click
    c = cyc;
    expect_evt(EvPress,       c + 1);
    expect_evt(EvRel,         c + 6);
    expect_evt(EvPress,       c + 6 + DblCyc);
    expect_evt(EvRel | EvDbl, c + 17);
    run(1'b1, 5);
    run(1'b0, DblCyc);
    run(1'b1, 3);
    run(1'b0, 12);

    // Fall exactly at hold expiry wins over long press
    c = cyc;
    expect_evt(EvPress, c + 1);
    expect_evt(EvRel,   c + 1 + LongCyc);
    expect_evt(EvClick, c + 1 + LongCyc + DblCyc);
    run(1'b1, LongCyc);
    run(1'b0, 15);

    // Second press held long: single long press, first click discarded
    c = cyc;
    expect_evt(EvPress, c + 1);
    expect_evt(EvRel,   c + 6);
    expect_evt(EvPress, c + 9);
    expect_evt(EvLong,  c + 9 + LongCyc);
    expect_evt(EvRel,   c + 34);
    run(1'b1, 5);
    run(1'b0, 3);
    run(1'b1, 25);
    run(1'b0, 15);

    checks++;
    assert (q.size() == 0) else begin
      failures++;
      $error("FAIL drain observed=%0d pending expected=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
